// File: rtl/dms_cfg_sequencer.sv
// dms_cfg_sequencer
// Loads a parallel configuration (key width exponent n, key d, caps mask
// capsN) into the serial decryption receiver. The bits go out on str while
// mode is high, in the receiver's load order: n[3:0], then d, then capsN,
// each MSB-first. Mode is held high with str=0 for a settle window and then
// dropped so the receiver enters data mode.
//
// Ports:
//   clk        system clock, posedge
//   reset      asynchronous, active-low
//   start      load request, sampled only in IDLE
//   abort      cancels a load in progress
//   n_in       key width exponent; key/caps length is 2**n_in bits
//   key_in     key d, bits [2**n_in-1:0] used
//   caps_in    caps mask, bits [2**n_in-1:0] used
//   str        serial configuration bit
//   mode       1 = receiver configuration mode, 0 = data mode
//   busy       load in progress
//   done       one-cycle pulse on successful completion
//   err        one-cycle pulse when start is rejected (n_in > MAX_N)
//   aborted    one-cycle pulse when abort cancels a load
//   cfg_valid  a complete configuration is loaded in the receiver
module dms_cfg_sequencer #(
  parameter int MAX_N         = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  n_in,
  input  logic [31:0] key_in,
  input  logic [31:0] caps_in,
  output logic        str,
  output logic        mode,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic        cfg_valid
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_N,
    SEND_KEY,
    SEND_CAPS,
    SETTLE
  } state_t;

  localparam logic [3:0] MAX_N_L   = 4'(MAX_N);
  localparam logic [5:0] SETTLE_LD = 6'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  n_sh;
  logic [31:0] key_sh;
  logic [31:0] caps_sh;
  logic [5:0]  cnt;      // index of the bit currently on str (or settle cycles left)
  logic [5:0]  cnt_dec;
  logic [5:0]  top;      // 2**n - 1: MSB index of key/caps

  assign cnt_dec = cnt - 6'd1;
  // n_sh never exceeds MAX_N (<= 5), so the shift cannot overflow 6 bits.
  assign top     = (6'd1 << n_sh) - 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_sh      <= '0;
      key_sh    <= '0;
      caps_sh   <= '0;
      cnt       <= '0;
      str       <= 1'b0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;

      // Abort outranks everything outside IDLE, including the final settle
      // cycle, so a cancelled load never reports done.
      if (state != IDLE && abort) begin
        state     <= IDLE;
        cnt       <= '0;
        str       <= 1'b0;
        mode      <= 1'b0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
        cfg_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (n_in > MAX_N_L) begin
                err <= 1'b1;
              end else begin
                n_sh      <= n_in;
                key_sh    <= key_in;
                caps_sh   <= caps_in;
                cnt       <= 6'd3;
                str       <= n_in[3];
                mode      <= 1'b1;
                busy      <= 1'b1;
                cfg_valid <= 1'b0;
                state     <= SEND_N;
              end
            end
          end

          SEND_N: begin
            if (cnt == 6'd0) begin
              str   <= key_sh[top[4:0]];
              cnt   <= top;
              state <= SEND_KEY;
            end else begin
              str <= n_sh[cnt_dec[1:0]];
              cnt <= cnt_dec;
            end
          end

          SEND_KEY: begin
            if (cnt == 6'd0) begin
              str   <= caps_sh[top[4:0]];
              cnt   <= top;
              state <= SEND_CAPS;
            end else begin
              str <= key_sh[cnt_dec[4:0]];
              cnt <= cnt_dec;
            end
          end

          SEND_CAPS: begin
            if (cnt == 6'd0) begin
              str   <= 1'b0;
              cnt   <= SETTLE_LD;
              state <= SETTLE;
            end else begin
              str <= caps_sh[cnt_dec[4:0]];
              cnt <= cnt_dec;
            end
          end

          SETTLE: begin
            if (cnt == 6'd0) begin
              mode      <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cfg_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt_dec;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dms_cfg_sequencer.sv
// Testbench for dms_cfg_sequencer: directed loads with hand-derived bit
// streams. Expected str bits and status pulses are queued when stimulus is
// issued; a negedge monitor pops and compares them as the DUT presents them.
module tb_dms_cfg_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  n_in = '0;
  logic [31:0] key_in = '0;
  logic [31:0] caps_in = '0;
  logic        str, mode, busy, done, err, aborted, cfg_valid;

  always #5 clk = ~clk;

  dms_cfg_sequencer #(
    .MAX_N        (5),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .n_in     (n_in),
    .key_in   (key_in),
    .caps_in  (caps_in),
    .str      (str),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .aborted  (aborted),
    .cfg_valid(cfg_valid)
  );

  int total = 0;
  int passed = 0;

  logic       exp_q[$];   // expected str bit for each mode-high cycle
  logic [2:0] ev_q[$];    // expected pulses as {done, err, aborted}
  logic       mon_bit;
  bit         mon_en = 1'b0;
  int         mode_cnt = 0;
  int         busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (mode) begin
        mode_cnt++;
        if (exp_q.size() == 0) chk("mode_unexpected", {31'd0, mode}, 32'd0);
        else begin
          mon_bit = exp_q.pop_front();
          chk("str_bit", {31'd0, str}, {31'd0, mon_bit});
        end
      end else begin
        chk("str_idle", {31'd0, str}, 32'd0);
      end
      if (busy) busy_cnt++;
      if (done || err || aborted) begin
        if (ev_q.size() == 0) chk("pulse_unexpected", {29'd0, done, err, aborted}, 32'd0);
        else chk("pulse", {29'd0, done, err, aborted}, {29'd0, ev_q.pop_front()});
      end
    end
  end

  task automatic push_load(input logic [3:0] n, input logic [31:0] k, input logic [31:0] c);
    int w;
    w = 1 << n;
    for (int i = 3; i >= 0; i--) exp_q.push_back(n[i]);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back(k[i]);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back(c[i]);
    for (int i = 0; i < SETTLE; i++) exp_q.push_back(1'b0);
    ev_q.push_back(3'b100);
  endtask

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic pulse_start(input logic [3:0] n, input logic [31:0] k, input logic [31:0] c);
    @(posedge clk); #1;
    n_in = n; key_in = k; caps_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ev_q.size() == 0 && exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_completes"}, {31'd0, ok}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {25'd0, str, mode, busy, done, err, aborted, cfg_valid}, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // Reset in the middle of SEND_KEY, then a normal load afterwards
    push_load(4'd2, 32'h0000000B, 32'h00000004);
    pulse_start(4'd2, 32'h0000000B, 32'h00000004);
    repeat (5) @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {25'd0, str, mode, busy, done, err, aborted, cfg_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    ev_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    // n=2: stream 0010 1011 0100 then 2 settle zeros
    mode_cnt = 0; busy_cnt = 0;
    push_load(4'd2, 32'h0000000B, 32'h00000004);
    pulse_start(4'd2, 32'h0000000B, 32'h00000004);
    chk("n2_cfg_valid_during", {31'd0, cfg_valid}, 32'd0);
    chk("n2_busy_during", {31'd0, busy}, 32'd1);
    wait_quiet("n2", 100);
    chk("n2_mode_cycles", mode_cnt, 14);
    chk("n2_busy_cycles", busy_cnt, 14);
    chk("n2_cfg_valid_after", {31'd0, cfg_valid}, 32'd1);

    // n=6 rejected: err pulse only, cfg_valid stays 1
    mode_cnt = 0; busy_cnt = 0;
    ev_q.push_back(3'b010);
    pulse_start(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_quiet("err", 20);
    chk("err_mode_cycles", mode_cnt, 0);
    chk("err_busy_cycles", busy_cnt, 0);
    chk("err_cfg_valid", {31'd0, cfg_valid}, 32'd1);

    // n=5: 32 key bits and 32 caps bits
    mode_cnt = 0; busy_cnt = 0;
    push_load(4'd5, 32'hA5A5A5A5, 32'h0F0F0F0F);
    pulse_start(4'd5, 32'hA5A5A5A5, 32'h0F0F0F0F);
    wait_quiet("n5", 200);
    chk("n5_mode_cycles", mode_cnt, 70);
    chk("n5_busy_cycles", busy_cnt, 70);
    chk("n5_cfg_valid_after", {31'd0, cfg_valid}, 32'd1);

    // n=3 with abort while the 3rd key bit is on str (key 0xC5 -> 1,1,0)
    mode_cnt = 0; busy_cnt = 0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    ev_q.push_back(3'b001);
    pulse_start(4'd3, 32'h000000C5, 32'h0000003A);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_mode_next", {31'd0, mode}, 32'd0);
    wait_quiet("abort", 20);
    chk("abort_mode_cycles", mode_cnt, 7);
    chk("abort_cfg_valid", {31'd0, cfg_valid}, 32'd0);

    // abort in IDLE has no effect
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_cfg_valid", {31'd0, cfg_valid}, 32'd0);

    // n=0 with start and abort together in IDLE: start wins
    mode_cnt = 0; busy_cnt = 0;
    push_load(4'd0, 32'h00000001, 32'h00000000);
    @(posedge clk); #1;
    n_in = 4'd0; key_in = 32'h1; caps_in = 32'h0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    wait_quiet("n0", 50);
    chk("n0_mode_cycles", mode_cnt, 8);
    chk("n0_cfg_valid_after", {31'd0, cfg_valid}, 32'd1);

    // n=1 load with a second start and changed inputs while busy
    mode_cnt = 0; busy_cnt = 0;
    push_load(4'd1, 32'h00000002, 32'h00000001);
    pulse_start(4'd1, 32'h00000002, 32'h00000001);
    n_in = 4'd4; key_in = 32'hFFFFFFFF; caps_in = 32'hFFFF0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = 32'h00000000;
    wait_quiet("busy_start", 50);
    chk("busy_start_mode_cycles", mode_cnt, 10);
    chk("busy_start_busy_cycles", busy_cnt, 10);
    chk("busy_start_cfg_valid", {31'd0, cfg_valid}, 32'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
